// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU fetch slice.
// Default widths and the fetch-stage state type.
package cpu_pkg;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/cpu_fetch_fifo.sv
// Small synchronous FIFO with clear and occupancy count.
// Push and pop may coincide at any occupancy; clear wins over both.
module cpu_fetch_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       clear_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [W-1:0]               data_i,
   output logic [W-1:0]               data_o,
   output logic [$clog2(DEPTH):0]     cnt_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (push_i & ~clear_i) mem_q[wptr_q] <= data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else if (clear_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_q + AW'(push_i);
         rptr_q <= rptr_q + AW'(pop_i);
         cnt_q  <= cnt_q + CW'(push_i) - CW'(pop_i);
      end
   end

   assign data_o = mem_q[rptr_q];
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch stage: issues in-order memory reads for the PC,
// buffers returned words with their PC, and hands them to decode.
module cpu_fetch #(
   parameter int ADDR_W = cpu_pkg::ADDR_W,
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int DEPTH  = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              pc_valid_i,
   output logic              pc_ready_o,
   input  logic              flush_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              instr_valid_o,
   output logic [DATA_W-1:0] instr_o,
   output logic [ADDR_W-1:0] instr_pc_o,
   input  logic              instr_ready_i,
   output logic              err_o
);

   import cpu_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t state_q, state_d;
   logic [CW-1:0] drop_q, drop_d;
   logic          err_q, err_d;

   // The PC queue occupancy doubles as the outstanding counter.
   logic [CW-1:0]             outst;
   logic [CW-1:0]             fifo_cnt;
   logic [ADDR_W-1:0]         pcq_head;
   logic [ADDR_W+DATA_W-1:0]  fifo_dout;

   logic run, valid, pop, can_issue, req, gnt, rv_ok;

   assign run       = (state_q == RUN);
   assign valid     = rst_ni & run & (fifo_cnt != '0);
   assign pop       = valid & instr_ready_i;
   assign can_issue = (({1'b0, outst} + {1'b0, fifo_cnt})
                       < (CW+1)'(DEPTH)) | pop;
   assign req       = rst_ni & run & pc_valid_i & can_issue & ~flush_i;
   assign gnt       = req & mem_gnt_i;
   assign rv_ok     = mem_rvalid_i & run & (outst != '0);

   always_comb begin
      state_d = state_q;
      drop_d  = drop_q;
      err_d   = err_q;
      unique case (state_q)
         RUN: begin
            if (mem_rvalid_i && outst == '0) err_d = 1'b1;
            if (flush_i) begin
               drop_d = outst - CW'(rv_ok);
               if (drop_d != '0) state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (mem_rvalid_i) begin
               drop_d = drop_q - CW'(1);
               if (drop_q == CW'(1)) state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RUN;
         drop_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
         err_q   <= err_d;
      end
   end

   cpu_fetch_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_pcq (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (flush_i),
      .push_i  (gnt),
      .pop_i   (rv_ok),
      .data_i  (pc_i),
      .data_o  (pcq_head),
      .cnt_o   (outst)
   );

   cpu_fetch_fifo #(.W(ADDR_W+DATA_W), .DEPTH(DEPTH)) u_ifq (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (flush_i),
      .push_i  (rv_ok),
      .pop_i   (pop),
      .data_i  ({pcq_head, mem_rdata_i}),
      .data_o  (fifo_dout),
      .cnt_o   (fifo_cnt)
   );

   assign mem_req_o     = req;
   assign mem_addr_o    = pc_i;
   assign pc_ready_o    = gnt;
   assign instr_valid_o = valid;
   assign instr_o       = valid ? fifo_dout[DATA_W-1:0] : '0;
   assign instr_pc_o    = valid ? fifo_dout[ADDR_W+DATA_W-1:DATA_W] : '0;
   assign err_o         = err_q;

endmodule

// File: tb/tb_cpu_fetch.sv
// Testbench for cpu_fetch: directed scenarios plus random traffic,
// all checked against a queue-based model of the fetch behaviour.
module tb_cpu_fetch;

   localparam int DEPTH = 2;

   logic       clk = 1'b0;
   logic       rst_ni = 1'b0;
   logic [3:0] pc_i = '0;
   logic       pc_valid_i = 1'b0;
   logic       pc_ready_o;
   logic       flush_i = 1'b0;
   logic       mem_req_o;
   logic [3:0] mem_addr_o;
   logic       mem_gnt_i = 1'b0;
   logic       mem_rvalid_i = 1'b0;
   logic [7:0] mem_rdata_i = '0;
   logic       instr_valid_o;
   logic [7:0] instr_o;
   logic [3:0] instr_pc_o;
   logic       instr_ready_i = 1'b0;
   logic       err_o;

   cpu_fetch #(.ADDR_W(4), .DATA_W(8), .DEPTH(DEPTH)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .pc_i          (pc_i),
      .pc_valid_i    (pc_valid_i),
      .pc_ready_o    (pc_ready_o),
      .flush_i       (flush_i),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_gnt_i     (mem_gnt_i),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rdata_i   (mem_rdata_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .instr_ready_i (instr_ready_i),
      .err_o         (err_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] pc;
      logic [7:0] d;
   } ent_t;

   // Model: mq = requests the memory still owes, ret_q = words for decode.
   logic [3:0] mq[$];
   ent_t       ret_q[$];
   int         drop = 0;
   bit         err_m = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input bit pv, input logic [3:0] pc, input bit gnt,
                      input bit rv, input logic [7:0] rd, input bit rdy,
                      input bit fl, output bit granted);
      bit v, pop, in_fl, req;
      logic [3:0] p;
      @(negedge clk);
      pc_valid_i = pv;
      pc_i = pc;
      mem_gnt_i = gnt;
      mem_rvalid_i = rv;
      mem_rdata_i = rd;
      instr_ready_i = rdy;
      flush_i = fl;
      #1;
      v = (ret_q.size() != 0);
      pop = v & rdy;
      in_fl = (drop != 0);
      req = pv && !fl && !in_fl &&
            ((mq.size() + ret_q.size() < DEPTH) || pop);
      chk("mem_req", mem_req_o, req);
      chk("pc_ready", pc_ready_o, req & gnt);
      if (req) chk("mem_addr", mem_addr_o, pc);
      chk("instr_valid", instr_valid_o, v);
      if (v) begin
         chk("instr_pc", instr_pc_o, ret_q[0].pc);
         chk("instr", instr_o, ret_q[0].d);
      end
      chk("err", err_o, err_m);
      if (pop) void'(ret_q.pop_front());
      if (rv) begin
         if (mq.size() == 0) err_m = 1'b1;
         else begin
            p = mq.pop_front();
            if (drop > 0) drop--;
            else if (!fl) ret_q.push_back('{pc: p, d: rd});
         end
      end
      if (fl && !in_fl) begin
         ret_q.delete();
         drop = mq.size();
      end
      if (req && gnt) mq.push_back(pc);
      granted = req & gnt;
   endtask

   task automatic do_reset();
      @(negedge clk);
      pc_valid_i = 1'b1;
      mem_gnt_i = 1'b1;
      instr_ready_i = 1'b1;
      mem_rvalid_i = 1'b0;
      flush_i = 1'b0;
      #2 rst_ni = 1'b0;
      #1;
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_pc_ready", pc_ready_o, 0);
      chk("rst_valid", instr_valid_o, 0);
      chk("rst_instr", instr_o, 0);
      chk("rst_instr_pc", instr_pc_o, 0);
      chk("rst_err", err_o, 0);
      mq.delete();
      ret_q.delete();
      drop = 0;
      err_m = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      pc_valid_i = 1'b0;
      mem_gnt_i = 1'b0;
      instr_ready_i = 1'b0;
      rst_ni = 1'b1;
   endtask

   task automatic drain();
      bit g;
      for (int i = 0; i < 12; i++) begin
         if (mq.size() == 0 && ret_q.size() == 0 && drop == 0) break;
         cyc(0, 4'h0, 0, mq.size() != 0, 8'($urandom), 1, 0, g);
      end
      chk("drained", mq.size() + ret_q.size() + drop, 0);
   endtask

   initial begin
      bit g;
      int p, ng, k, nret;
      logic [3:0] pcs [3];
      pcs[0] = 4'hE;
      pcs[1] = 4'hF;
      pcs[2] = 4'h0;

      do_reset();

      // Streaming fetch of PCs 0..3 with single-cycle memory latency
      p = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(p < 4, 4'(p), 1, mq.size() != 0, 8'($urandom), 1, 0, g);
         if (g) p++;
      end
      chk("stream_issued", p, 4);
      drain();

      // Decode stalled: exactly DEPTH grants, then back-pressure
      ng = 0;
      for (int i = 0; i < 6; i++) begin
         cyc(1, 4'(4 + ng), 1, mq.size() != 0, 8'($urandom), 0, 0, g);
         if (g) ng++;
      end
      chk("stall_grants", ng, 2);
      chk("stall_no_req", mem_req_o, 0);
      drain();

      // PC wrap with fixed data
      p = 0;
      k = 0;
      nret = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(p < 3, pcs[p % 3], 1, mq.size() != 0, 8'(8'hA1 + nret),
             1, 0, g);
         if (mem_rvalid_i) nret++;
         if (instr_valid_o && k < 3) begin
            chk("wrap_pc", instr_pc_o, pcs[k]);
            chk("wrap_data", instr_o, 8'(8'hA1 + k));
            k++;
         end
         if (g) p++;
      end
      chk("wrap_count", k, 3);
      drain();

      // Flush with two fetches in flight
      cyc(1, 4'h5, 1, 0, 8'h00, 1, 0, g);
      cyc(1, 4'h6, 1, 0, 8'h00, 1, 0, g);
      cyc(1, 4'h7, 1, 0, 8'h00, 1, 1, g);
      cyc(1, 4'h7, 1, 0, 8'h00, 1, 0, g);
      cyc(1, 4'h7, 1, 1, 8'h55, 1, 0, g);
      cyc(1, 4'h7, 1, 1, 8'h66, 1, 0, g);
      chk("flush_hold", mem_req_o, 0);
      cyc(1, 4'h7, 1, 0, 8'h00, 1, 0, g);
      chk("flush_resume", mem_req_o, 1);
      drain();

      // Spurious response with nothing outstanding
      cyc(0, 4'h0, 0, 1, 8'h99, 1, 0, g);
      for (int i = 0; i < 3; i++) cyc(0, 4'h0, 0, 0, 8'h00, 1, 0, g);
      chk("err_sticky", err_o, 1);

      // Fill the instruction FIFO, then reset asynchronously
      cyc(1, 4'h1, 1, 0, 8'h00, 0, 0, g);
      cyc(1, 4'h2, 1, 1, 8'h11, 0, 0, g);
      cyc(1, 4'h3, 1, 1, 8'h22, 0, 0, g);
      chk("full_valid", instr_valid_o, 1);
      do_reset();
      cyc(1, 4'h9, 1, 0, 8'h00, 1, 0, g);
      chk("post_rst_req", mem_req_o, 1);
      drain();

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         cyc($urandom_range(0, 3) != 0, 4'($urandom),
             $urandom_range(0, 3) != 0,
             mq.size() != 0 && $urandom_range(0, 1) == 1,
             8'($urandom), $urandom_range(0, 2) != 0,
             $urandom_range(0, 19) == 0, g);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_fetch.md
# cpu_fetch

Instruction fetch stage directly downstream of the CPU program counter. Takes the current 4-bit PC, issues in-order read requests to instruction memory over a request/grant/rvalid interface, buffers returned words with their PC in a small FIFO, and presents them to decode over a valid/ready handshake. Back-pressures the PC via `pc_ready_o`, which the counter uses as its increment enable. Supports a flush that discards buffered and in-flight fetches.

## Interface
- `ADDR_W`, 4, PC / instruction address width
- `DATA_W`, 8, instruction word width
- `DEPTH`, 2, max fetches in flight plus buffered (power of two, ≥2)

- `clk_i` input 1: clock, all logic on rising edge
- `rst_ni` input 1: one clock; reset is asynchronous and active-low
- `pc_i` input ADDR_W: address to fetch
- `pc_valid_i` input 1: `pc_i` valid
- `pc_ready_o` output 1: fetch of `pc_i` accepted this cycle; PC advances
- `flush_i` input 1: discard all buffered and outstanding fetches
- `mem_req_o` output 1: memory read request
- `mem_addr_o` output ADDR_W: request address (= `pc_i`)
- `mem_gnt_i` input 1: request accepted
- `mem_rvalid_i` input 1: read data valid, in request order
- `mem_rdata_i` input DATA_W: read data
- `instr_valid_o` output 1: instruction available to decode
- `instr_o` output DATA_W: instruction word
- `instr_pc_o` output ADDR_W: PC of `instr_o`
- `instr_ready_i` input 1: decode accepts instruction
- `err_o` output 1: sticky, rvalid received with nothing outstanding

## Operation
- Counters: `outstanding` (granted, no rvalid yet), `fifo_cnt` (buffered), both 0..DEPTH, width clog2(DEPTH)+1.
- `can_issue` = (`outstanding` + `fifo_cnt` < DEPTH) or a pop occurs this cycle.
- States: RUN, FLUSH.
- RUN: `mem_req_o` = `pc_valid_i` & `can_issue` & ~`flush_i`; `mem_addr_o` = `pc_i`; `pc_ready_o` = `mem_req_o` & `mem_gnt_i`. On grant, `pc_i` pushed into internal PC queue, `outstanding`+1.
- rvalid: pops PC queue head, pushes {pc, rdata} into FIFO, `outstanding`-1. Grant and rvalid in same cycle: `outstanding` unchanged.
- Output: `instr_valid_o` = `fifo_cnt` ≠ 0; pop on `instr_valid_o` & `instr_ready_i`. Simultaneous push and pop legal at any occupancy, including full.
- `flush_i` (any state): FIFO and PC queue cleared next cycle; `drop` = `outstanding` minus rvalid this cycle; no request issued in flush cycle. If `drop` ≠ 0 → FLUSH, else stay RUN.
- FLUSH: `mem_req_o`=0, `instr_valid_o`=0; each rvalid decrements `drop`, data discarded; `drop` reaching 0 → RUN. `flush_i` in FLUSH: no effect beyond staying in FLUSH.
- rvalid with `outstanding`=0 and `drop`=0: ignored, `err_o` set until reset.

## Timing
- Reset (while `rst_ni` low and after): state RUN, all counters 0, `mem_req_o`=0, `pc_ready_o`=0, `instr_valid_o`=0, `instr_o`=0, `instr_pc_o`=0, `err_o`=0. Outputs forced low during reset regardless of inputs.
- Grant in cycle N, earliest rvalid N+1, earliest `instr_valid_o` N+2 (FIFO registered, no bypass).
- Zero-wait memory and decode: one instruction per cycle sustained with DEPTH=2 only when rvalid arrives N+1; throughput = DEPTH / round-trip latency.
- Request path combinational from `pc_valid_i`, `mem_gnt_i`, `instr_ready_i`; all state registered.
- Reset mid-operation: all in-flight fetches forgotten; memory responses after reset release with `outstanding`=0 set `err_o` (system must reset memory concurrently).

## Structure
- `cpu_pkg`: `ADDR_W`, `DATA_W` defaults, `fetch_state_t` enum {RUN, FLUSH}.
- Sub-module `cpu_fetch_fifo`: parameterised synchronous FIFO (width, depth), push/pop/clear, count output; instanced twice (PC queue width ADDR_W, instruction FIFO width ADDR_W+DATA_W).

## Test plan
- Reset release, `pc_valid_i`=1, pc 0..3, grant always, rvalid N+1, ready=1 → `instr_pc_o` 0,1,2,3 on consecutive cycles, first `instr_valid_o` two cycles after first grant.
- `instr_ready_i`=0, rvalid N+1 → exactly 2 grants, then `mem_req_o`=0 and `pc_ready_o`=0 until a pop; no lost or duplicated words.
- PC wrap: pc 0xE,0xF,0x0 with data 0xA1,0xA2,0xA3 → output pairs (E,A1),(F,A2),(0,A3) in order.
- Two outstanding, `flush_i` pulsed, rvalids arrive 2 and 3 cycles later → both discarded, FLUSH held, `mem_req_o` resumes the cycle after second rvalid; `instr_valid_o` stays 0.
- Spurious `mem_rvalid_i` with nothing outstanding → `err_o`=1 and held; FIFO unchanged; clears only on `rst_ni` low.
- Assert `rst_ni` low with FIFO full → all outputs 0 immediately (asynchronous), counters 0 on release.
